// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: issues one fetch per retired instruction, hands the
// fetched word to decode, and locks up in FAULT on a misaligned PC or a bus
// error until the next reset. Every output comes straight from a register.
module ysyx_24110015_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory request channel
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    // instruction memory response channel
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    // decode-stage handoff
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    // next PC from write-back
    input  logic        npc_valid,
    input  logic [31:0] npc,
    // status
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        OUT,
        NEXT,
        FAULT
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg;
    logic [31:0] inst_pc_reg;
    logic [31:0] fetch_cnt_reg;
    logic        req_valid_reg;
    logic        inst_valid_reg;
    logic        fault_reg;

    // The fetch address is the PC itself; it only changes in NEXT, so it is
    // naturally stable while a request is waiting for acceptance.
    assign imem_addr      = pc_reg;
    assign imem_req_valid = req_valid_reg;
    assign inst_valid     = inst_valid_reg;
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
    assign fetch_fault    = fault_reg;
    assign fetch_cnt      = fetch_cnt_reg;

    // Fetch sequencer: state, PC, captured instruction and registered handshake outputs.
    // imem_req_valid is precomputed on entry to REQ from the PC being loaded, so
    // a misaligned PC never raises a request before REQ diverts to FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            inst_reg       <= NOP;
            inst_pc_reg    <= RESET_PC;
            fetch_cnt_reg  <= 32'd0;
            req_valid_reg  <= 1'b0;
            inst_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg     <= REQ;
                    req_valid_reg <= (pc_reg[1:0] == 2'b00);
                end
                REQ: begin
                    if (pc_reg[1:0] != 2'b00) begin
                        state_reg     <= FAULT;
                        req_valid_reg <= 1'b0;
                        fault_reg     <= 1'b1;
                    end else if (imem_req_ready) begin
                        state_reg     <= WAIT;
                        req_valid_reg <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (imem_rsp_err) begin
                            state_reg <= FAULT;
                            fault_reg <= 1'b1;
                        end else begin
                            state_reg      <= OUT;
                            inst_reg       <= imem_rsp_data;
                            inst_pc_reg    <= pc_reg;
                            inst_valid_reg <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (inst_ready) begin
                        state_reg      <= NEXT;
                        inst_valid_reg <= 1'b0;
                        fetch_cnt_reg  <= fetch_cnt_reg + 32'd1;
                    end
                end
                NEXT: begin
                    if (npc_valid) begin
                        state_reg     <= REQ;
                        pc_reg        <= npc;
                        req_valid_reg <= (npc[1:0] == 2'b00);
                    end
                end
                FAULT: begin
                    req_valid_reg  <= 1'b0;
                    inst_valid_reg <= 1'b0;
                    fault_reg      <= 1'b1;
                end
                default: begin
                    state_reg      <= IDLE;
                    req_valid_reg  <= 1'b0;
                    inst_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Self-checking bench for the fetch unit: a table of fetch transactions with
// varied memory/decode delays, then hand-written fault and reset sequences.
module tb_ysyx_24110015_ifu;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int    checks = 0;
    int    errors = 0;
    string cur    = "init";

    ysyx_24110015_ifu #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .fetch_fault    (fetch_fault),
        .fetch_cnt      (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something wedges despite the bounded waits.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;        // reset before this fetch
        int          ready_dly;  // cycles imem_req_ready held low
        int          rsp_lat;    // response latency after acceptance (>=1)
        int          dec_dly;    // cycles inst_ready held low in OUT
        logic [31:0] data;
        logic [31:0] exp_pc;
        logic [31:0] exp_cnt;    // fetch_cnt after the handshake
        logic [31:0] npc;
        int          npc_dly;    // cycles after handshake before npc_valid
        bit          stray;      // drive stray rsp/npc pulses outside their states
        bit          force_max;  // preload fetch_cnt with all ones
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", cur, name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        npc_valid      = 1'b0;
        npc            = 32'h0;
    endtask

    // Reset, check reset values, release, and check first request timing.
    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        chk("rst_inst", inst, 32'h0000_0013);
        chk("rst_addr", imem_addr, 32'h8000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        chk("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("first_addr", imem_addr, 32'h8000_0000);
    endtask

    // One complete fetch: request, response, decode handshake, next PC.
    task automatic run_vec(input vec_t v);
        int n;
        if (v.rst) do_reset();
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, v.exp_pc);
        for (int i = 0; i < v.ready_dly; i++) begin
            @(negedge clk);
            chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("req_hold_addr", imem_addr, v.exp_pc);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        chk("req_drop", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 1; i < v.rsp_lat; i++) begin
            @(negedge clk);
            chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        if (v.force_max) begin
            force dut.fetch_cnt_reg = 32'hFFFF_FFFF;
            #1;
            release dut.fetch_cnt_reg;
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = v.data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        chk("out_valid", {31'd0, inst_valid}, 32'd1);
        chk("out_inst", inst, v.data);
        chk("out_pc", inst_pc, v.exp_pc);
        chk("out_cnt", fetch_cnt, v.exp_cnt - 32'd1);
        for (int i = 0; i < v.dec_dly; i++) begin
            if (v.stray) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                npc_valid      = 1'b1;
                npc            = 32'h9000_0000;
            end
            @(negedge clk);
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_inst", inst, v.data);
            chk("hold_pc", inst_pc, v.exp_pc);
            chk("hold_cnt", fetch_cnt, v.exp_cnt - 32'd1);
            chk("hold_req", {31'd0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        npc_valid      = 1'b0;
        inst_ready     = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        chk("hs_valid", {31'd0, inst_valid}, 32'd0);
        chk("hs_cnt", fetch_cnt, v.exp_cnt);
        $display("fetch %s pc=%h inst=%h cnt=%0d", cur, inst_pc, inst, fetch_cnt);
        for (int i = 0; i < v.npc_dly; i++) begin
            if (v.stray) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            chk("next_req", {31'd0, imem_req_valid}, 32'd0);
            chk("next_inst", inst, v.data);
        end
        imem_rsp_valid = 1'b0;
        npc_valid      = 1'b1;
        npc            = v.npc;
        @(negedge clk);
        npc_valid = 1'b0;
        chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        clear_inputs();

        //            rst rdy lat dec data          exp_pc        cnt    npc           nd str frc
        vecs[0] = '{1'b1, 0, 1, 0, 32'h0010_0093, 32'h8000_0000, 32'd1, 32'h8000_0004, 0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 0, 1, 0, 32'h0010_0093, 32'h8000_0004, 32'd2, 32'h8000_0008, 0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 0, 1, 0, 32'h0010_0093, 32'h8000_0008, 32'd3, 32'h8000_000C, 0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 2, 3, 1, 32'h0000_0513, 32'h8000_000C, 32'd4, 32'h8000_1000, 2, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 0, 2, 4, 32'hFFF0_0113, 32'h8000_1000, 32'd5, 32'h8000_0000, 0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 5, 1, 0, 32'h0000_0073, 32'h8000_0000, 32'd1, 32'h8000_0004, 1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1, 4, 2, 32'h00A0_0293, 32'h8000_0004, 32'd2, 32'h8000_0008, 0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 0, 1, 3, 32'h1234_5678, 32'h8000_0008, 32'd0, 32'h8000_000C, 0, 1'b0, 1'b1};

        for (int k = 0; k < 8; k++) begin
            cur = $sformatf("vec%0d", k);
            run_vec(vecs[k]);
        end

        // Misaligned next PC: no request, straight to a sticky fault.
        cur = "misaligned";
        v = '{1'b1, 0, 1, 0, 32'h0010_0093, 32'h8000_0000, 32'd1, 32'h8000_0102, 0, 1'b0, 1'b0};
        run_vec(v);
        chk("mis_req", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'b1;
            npc_valid      = 1'b1;
            npc            = 32'h8000_0200;
            @(negedge clk);
            chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
            chk("mis_req_off", {31'd0, imem_req_valid}, 32'd0);
            chk("mis_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        clear_inputs();

        // Bus error response: fault, captured instruction untouched.
        cur = "rsp_err";
        do_reset();
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_err   = 1'b1;
        imem_rsp_data  = 32'h0BAD_F00D;
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("err_fault", {31'd0, fetch_fault}, 32'd1);
            chk("err_inst", inst, 32'h0000_0013);
            chk("err_inst_valid", {31'd0, inst_valid}, 32'd0);
            chk("err_req", {31'd0, imem_req_valid}, 32'd0);
            @(negedge clk);
        end

        // Reset pulled in WAIT, then a stray response after release.
        cur = "rst_in_wait";
        v = '{1'b1, 0, 1, 0, 32'h0010_0093, 32'h8000_0000, 32'd1, 32'h8000_0004, 0, 1'b0, 1'b0};
        run_vec(v);
        chk("pre_addr", imem_addr, 32'h8000_0004);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req", {31'd0, imem_req_valid}, 32'd0);
        chk("abort_cnt", fetch_cnt, 32'd0);
        chk("abort_addr", imem_addr, 32'h8000_0000);
        chk("abort_inst", inst, 32'h0000_0013);
        @(negedge clk);
        rst_n          = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        chk("post_req", {31'd0, imem_req_valid}, 32'd1);
        chk("post_addr", imem_addr, 32'h8000_0000);
        chk("post_inst", inst, 32'h0000_0013);
        chk("post_inst_valid", {31'd0, inst_valid}, 32'd0);
        v = '{1'b0, 0, 2, 1, 32'h0040_0113, 32'h8000_0000, 32'd1, 32'h8000_0004, 0, 1'b0, 1'b0};
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_24110015_ifu.md
YSYX_24110015_IFU -- requirements
Module: ysyx_24110015_ifu

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 imem_req_valid  output  1  SHALL flag a fetch request to instruction memory.
REQ-005 imem_req_ready  input  1  SHALL be memory acceptance of the request.
REQ-006 imem_addr  output  32  SHALL carry the fetch address, equal to pc.
REQ-007 imem_rsp_valid  input  1  SHALL flag returned instruction data.
REQ-008 imem_rsp_data  input  32  SHALL carry the returned instruction word.
REQ-009 imem_rsp_err  input  1  SHALL flag a bus error on the response.
REQ-010 inst_valid  output  1  SHALL flag a valid instruction to the decode stage.
REQ-011 inst_ready  input  1  SHALL be decode-stage acceptance.
REQ-012 inst  output  32  SHALL carry the fetched instruction.
REQ-013 inst_pc  output  32  SHALL carry the PC of inst.
REQ-014 npc_valid  input  1  SHALL flag that the write-back stage has retired the instruction.
REQ-015 npc  input  32  SHALL carry the next PC from write-back.
REQ-016 fetch_fault  output  1  SHALL flag a sticky fetch fault.
REQ-017 fetch_cnt  output  32  SHALL count instructions handed to decode.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, OUT, NEXT and FAULT, all encoded in one state register.
REQ-019 IDLE SHALL go to REQ unconditionally on the next edge; imem_req_valid SHALL be 0 in IDLE.
REQ-020 REQ with pc[1:0]!=0 SHALL go to FAULT without asserting imem_req_valid.
REQ-021 REQ with aligned pc SHALL assert imem_req_valid, and SHALL go to WAIT on the edge where imem_req_ready=1.
REQ-022 imem_addr and imem_req_valid SHALL stay stable while imem_req_valid=1 and imem_req_ready=0.
REQ-023 WAIT SHALL accept a response of any latency of 1 or more cycles after acceptance; imem_rsp_valid outside WAIT SHALL be ignored.
REQ-024 WAIT with imem_rsp_valid=1 and imem_rsp_err=1 SHALL go to FAULT.
REQ-025 WAIT with imem_rsp_valid=1 and imem_rsp_err=0 SHALL latch imem_rsp_data into inst and go to OUT.
REQ-026 OUT SHALL assert inst_valid, with inst and inst_pc held stable until handshake.
REQ-027 On inst_valid=1 and inst_ready=1, OUT SHALL go to NEXT, and fetch_cnt SHALL increment by 1, wrapping from 32'hFFFF_FFFF to 0.
REQ-028 NEXT SHALL wait for npc_valid, then load pc with npc and go to REQ; npc_valid outside NEXT SHALL be ignored.
REQ-029 FAULT SHALL be terminal until reset: fetch_fault=1, imem_req_valid=0, inst_valid=0.
REQ-030 inst_pc SHALL equal the pc value used for the request that returned inst.
REQ-031 No combinational path SHALL exist from any input to imem_req_valid or inst_valid.

Reset
REQ-032 While rst_n=0, the block SHALL hold: state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), fetch_cnt=0, fetch_fault=0, imem_req_valid=0, inst_valid=0.
REQ-033 Assertion of rst_n mid-transaction (REQ, WAIT, OUT or NEXT) SHALL abort immediately to the reset values; a response arriving after reset release SHALL be ignored (block is in IDLE/REQ).
REQ-034 The first imem_req_valid after reset SHALL appear in the second cycle after rst_n rises (IDLE then REQ), with imem_addr=RESET_PC.

Verification
REQ-035 Zero-wait memory (ready=1, rsp 1 cycle later, data 32'h00100093), inst_ready=1, npc=pc+4 one cycle after handshake -> three instructions at inst_pc 0x80000000/04/08, fetch_cnt=3, no fault.
REQ-036 imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr=0x80000000 stable all 5 cycles; WAIT entered on the 6th.
REQ-037 inst_ready held 0 for 4 cycles in OUT -> inst, inst_pc and inst_valid stable; fetch_cnt increments only on the handshake edge.
REQ-038 npc=32'h8000_0102 -> FAULT with no memory request; fetch_fault=1, imem_req_valid=0 thereafter. Response with imem_rsp_err=1 -> FAULT, inst unchanged.
REQ-039 rst_n pulled low in WAIT, then a stray imem_rsp_valid after release -> outputs at reset values, response ignored, fresh request at 0x80000000.
REQ-040 fetch_cnt forced to 32'hFFFF_FFFF via a long run or force, then one handshake -> fetch_cnt=0.
